// File: rtl/output_buffer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// output_buffer_ctrl_pkg
//   Shared configuration for the output-buffer sequencer: default array
//   geometry (overridable through the ARRAYWIDTH / DSP_DELAY macros), the
//   FSM state encoding and a constant-safe ceil(log2) helper for counter
//   widths.
// ----------------------------------------------------------------------------
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 8
`endif
`ifndef DSP_DELAY
`define DSP_DELAY 3
`endif

package output_buffer_ctrl_pkg;

   localparam int DEF_ARRAYWIDTH = `ARRAYWIDTH;
   localparam int DEF_DSP_DELAY  = `DSP_DELAY;
   localparam int DEF_KTILE_W    = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_NEXT  = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Never returns less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/output_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// output_buffer_ctrl
//   Sequences the systolic-array output buffer for one output-tile job:
//   CLEAR, then K accumulation passes of ARRAYWIDTH*DSP_DELAY load beats
//   (separated by a one-cycle NEXT), then ARRAYWIDTH drain beats and a
//   one-cycle done pulse.
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   start, num_ktiles    job request from the scheduler and pass count
//   abort                synchronous abort of a running job
//   res_valid, out_ready flow control from the array / downstream
//   load_en, load_clear, acc_enable, acc_clear, out_en  buffer strobes
//   out_valid, busy, done status to downstream / scheduler
// ----------------------------------------------------------------------------
module output_buffer_ctrl
   import output_buffer_ctrl_pkg::*;
#(
   parameter int ARRAYWIDTH = DEF_ARRAYWIDTH,
   parameter int DSP_DELAY  = DEF_DSP_DELAY,
   parameter int KTILE_W    = DEF_KTILE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KTILE_W-1:0] num_ktiles,
   input  logic               abort,
   input  logic               res_valid,
   input  logic               out_ready,
   output logic               load_en,
   output logic               load_clear,
   output logic               acc_enable,
   output logic               acc_clear,
   output logic               out_en,
   output logic               out_valid,
   output logic               busy,
   output logic               done
);

   localparam int LOAD_BEATS = ARRAYWIDTH * DSP_DELAY;
   localparam int LCNT_W     = clog2(LOAD_BEATS);
   localparam int DCNT_W     = clog2(ARRAYWIDTH);

   localparam logic [LCNT_W-1:0]  LOAD_LAST  = LCNT_W'(LOAD_BEATS - 1);
   localparam logic [DCNT_W-1:0]  DRAIN_LAST = DCNT_W'(ARRAYWIDTH - 1);
   localparam logic [LCNT_W-1:0]  L_ONE      = LCNT_W'(1'b1);
   localparam logic [DCNT_W-1:0]  D_ONE      = DCNT_W'(1'b1);
   localparam logic [KTILE_W-1:0] K_ONE      = KTILE_W'(1'b1);

   state_t               r_state;
   state_t               w_next;
   logic [LCNT_W-1:0]    r_load_cnt;
   logic [DCNT_W-1:0]    r_drain_cnt;
   logic [KTILE_W-1:0]   r_tile_cnt;
   logic [KTILE_W-1:0]   r_k;

   logic                 w_abort;
   logic                 w_start;
   logic                 w_last_pass;
   logic [KTILE_W-1:0]   w_k_in;
   logic                 w_load_en;
   logic                 w_load_clear;
   logic                 w_acc_enable;
   logic                 w_acc_clear;
   logic                 w_out_en;
   logic                 w_done;

   // abort only matters while a job is running; start only while idle
   assign w_abort     = abort && (r_state != S_IDLE);
   assign w_start     = start && (r_state == S_IDLE);
   assign w_k_in      = (num_ktiles == {KTILE_W{1'b0}}) ? K_ONE : num_ktiles;
   assign w_last_pass = (r_tile_cnt == (r_k - K_ONE));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and strobe decode; abort overrides everything for one cycle
   always_comb begin
      w_next       = r_state;
      w_load_en    = 1'b0;
      w_load_clear = 1'b0;
      w_acc_enable = 1'b0;
      w_acc_clear  = 1'b0;
      w_out_en     = 1'b0;
      w_done       = 1'b0;
      if (w_abort) begin
         w_load_clear = 1'b1;
         w_acc_clear  = 1'b1;
         w_next       = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_next = S_CLEAR;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_CLEAR: begin
               w_load_clear = 1'b1;
               w_acc_clear  = 1'b1;
               w_next       = S_LOAD;
            end
            S_LOAD: begin
               w_load_en    = res_valid;
               w_acc_enable = (r_tile_cnt != {KTILE_W{1'b0}});
               if (res_valid && (r_load_cnt == LOAD_LAST)) begin
                  w_next = w_last_pass ? S_DRAIN : S_NEXT;
               end else begin
                  w_next = S_LOAD;
               end
            end
            S_NEXT: begin
               w_load_clear = 1'b1;
               w_next       = S_LOAD;
            end
            S_DRAIN: begin
               w_out_en = out_ready;
               if (out_ready && (r_drain_cnt == DRAIN_LAST)) begin
                  w_next = S_DONE;
               end else begin
                  w_next = S_DRAIN;
               end
            end
            S_DONE: begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   // Load beat counter, restarted at the top of every pass
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_load_cnt <= {LCNT_W{1'b0}};
      end else if (w_abort || (r_state == S_CLEAR) || (r_state == S_NEXT)) begin
         r_load_cnt <= {LCNT_W{1'b0}};
      end else if (w_load_en) begin
         r_load_cnt <= r_load_cnt + L_ONE;
      end else begin
         r_load_cnt <= r_load_cnt;
      end
   end

   // Drain beat counter; returns to 0 after the last beat for any ARRAYWIDTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drain_cnt <= {DCNT_W{1'b0}};
      end else if (w_abort || (r_state == S_CLEAR)) begin
         r_drain_cnt <= {DCNT_W{1'b0}};
      end else if (w_out_en) begin
         r_drain_cnt <= (r_drain_cnt == DRAIN_LAST) ? {DCNT_W{1'b0}} : (r_drain_cnt + D_ONE);
      end else begin
         r_drain_cnt <= r_drain_cnt;
      end
   end

   // Accumulation pass counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tile_cnt <= {KTILE_W{1'b0}};
      end else if (w_abort || w_start) begin
         r_tile_cnt <= {KTILE_W{1'b0}};
      end else if (r_state == S_NEXT) begin
         r_tile_cnt <= r_tile_cnt + K_ONE;
      end else begin
         r_tile_cnt <= r_tile_cnt;
      end
   end

   // Pass count latched at job start so later num_ktiles changes are ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k <= K_ONE;
      end else if (w_start) begin
         r_k <= w_k_in;
      end else begin
         r_k <= r_k;
      end
   end

   assign load_en    = w_load_en;
   assign load_clear = w_load_clear;
   assign acc_enable = w_acc_enable;
   assign acc_clear  = w_acc_clear;
   assign out_en     = w_out_en;
   assign out_valid  = w_out_en;
   assign busy       = (r_state != S_IDLE);
   assign done       = w_done;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_output_buffer_ctrl
//   Directed bench for output_buffer_ctrl with ARRAYWIDTH=4, DSP_DELAY=3.
//   Each cycle the expected strobe vector is derived from the job timeline
//   and the stimulus pattern, queued, then popped and compared at negedge.
//   Vector layout: {load_en, load_clear, acc_enable, acc_clear,
//                   out_en, out_valid, busy, done}
// ----------------------------------------------------------------------------
module tb_output_buffer_ctrl;

   localparam int AW = 4;
   localparam int DD = 3;
   localparam int LB = AW * DD;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] num_ktiles;
   logic       abort;
   logic       res_valid;
   logic       out_ready;
   logic       load_en;
   logic       load_clear;
   logic       acc_enable;
   logic       acc_clear;
   logic       out_en;
   logic       out_valid;
   logic       busy;
   logic       done;

   int         checks;
   int         errors;
   int         cyc;
   logic [7:0] sb_q[$];

   output_buffer_ctrl #(
      .ARRAYWIDTH (AW),
      .DSP_DELAY  (DD),
      .KTILE_W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_ktiles (num_ktiles),
      .abort      (abort),
      .res_valid  (res_valid),
      .out_ready  (out_ready),
      .load_en    (load_en),
      .load_clear (load_clear),
      .acc_enable (acc_enable),
      .acc_clear  (acc_clear),
      .out_en     (out_en),
      .out_valid  (out_valid),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
   end

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   function automatic logic [7:0] mk(input logic le, input logic lc, input logic ae,
                                     input logic ac, input logic oe, input logic bz,
                                     input logic dn);
      return {le, lc, ae, ac, oe, oe, bz, dn};
   endfunction

   // drive one cycle of inputs, queue its expectation, check at negedge
   task automatic step(input logic s, input logic a, input logic v, input logic r,
                       input logic [7:0] exp, input string tag);
      logic [7:0] got;
      logic [7:0] want;
      start     = s;
      abort     = a;
      res_valid = v;
      out_ready = r;
      sb_q.push_back(exp);
      @(negedge clk);
      got  = {load_en, load_clear, acc_enable, acc_clear, out_en, out_valid, busy, done};
      want = sb_q.pop_front();
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, want);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int k_req, input bit v_toggle, input bit r_stall,
                          input int abort_beat, input bit start_in_load,
                          input bit abort_with_start, input string tag);
      int   k;
      int   beats;
      int   idx;
      int   stall;
      logic v;
      logic r;
      logic s;
      k = (k_req == 0) ? 1 : k_req;
      num_ktiles = 8'(k_req);
      step(1'b1, abort_with_start, 1'b0, 1'b0, mk(0,0,0,0,0,0,0), {tag, "_start"});
      num_ktiles = 8'd7;
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(0,1,0,1,0,1,0), {tag, "_clear"});
      idx = 0;
      for (int p = 0; p < k; p++) begin
         beats = 0;
         while (beats < LB) begin
            v = v_toggle ? ((idx % 2) == 0) : 1'b1;
            idx++;
            s = start_in_load && (p == 0) && (beats == 3);
            if ((abort_beat >= 0) && (p == 0) && (beats == abort_beat) && v) begin
               step(s, 1'b1, v, 1'b1, mk(0,1,0,1,0,1,0), {tag, "_abort"});
               step(1'b0, 1'b0, v, 1'b1, mk(0,0,0,0,0,0,0), {tag, "_abort_idle"});
               return;
            end
            step(s, 1'b0, v, 1'b1, mk(v,0,(p != 0),0,0,1,0), {tag, "_load"});
            if (v) beats++;
         end
         if (p < k - 1) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, mk(0,1,0,0,0,1,0), {tag, "_next"});
         end
      end
      beats = 0;
      stall = 0;
      while (beats < AW) begin
         r = !(r_stall && (beats == 2) && (stall < 5));
         if (!r) stall++;
         step(1'b0, 1'b0, 1'b1, r, mk(0,0,0,0,r,1,0), {tag, "_drain"});
         if (r) beats++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,1,1), {tag, "_done"});
      step(1'b0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0), {tag, "_idle"});
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      res_valid  = 1'b0;
      out_ready  = 1'b0;
      num_ktiles = 8'd1;
      #2;
      rst = 1'b0;
      // reset holds everything low even with start and res_valid asserted
      step(1'b1, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0), "reset_a");
      step(1'b1, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0), "reset_b");
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0), "idle");

      run_job(1, 1'b0, 1'b0, -1, 1'b0, 1'b0, "t1_k1");
      run_job(3, 1'b0, 1'b0, -1, 1'b0, 1'b0, "t2_k3");
      run_job(1, 1'b1, 1'b0, -1, 1'b0, 1'b0, "t3_toggle");
      run_job(1, 1'b0, 1'b1, -1, 1'b0, 1'b0, "t4_stall");
      run_job(1, 1'b0, 1'b0,  5, 1'b0, 1'b0, "t5_abort");
      run_job(1, 1'b0, 1'b0, -1, 1'b0, 1'b0, "t5_rerun");
      run_job(0, 1'b0, 1'b0, -1, 1'b1, 1'b0, "t6_k0");

      // abort while idle is ignored
      step(1'b0, 1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,0,0), "idle_abort");
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0), "idle_abort_after");
      // start and abort together in idle: start wins
      run_job(2, 1'b0, 1'b0, -1, 1'b0, 1'b1, "start_abort");

      // reset in the middle of a job
      num_ktiles = 8'd1;
      step(1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0), "mrst_start");
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(0,1,0,1,0,1,0), "mrst_clear");
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,1,0), "mrst_load");
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0), "mrst_reset");
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0), "mrst_idle");
      run_job(1, 1'b0, 1'b0, -1, 1'b0, 1'b0, "mrst_recover");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
